// File: rtl/apply_case_scheduler.sv
// apply_case_scheduler: round-robin front end sharing one simple-case checker.
// Define APPLY_SCHED_BACK_TO_BACK_EN to let RESP hand off straight to the next grant.
module apply_case_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TYPE_W  = 3,
  parameter int INDEX_W = 30,
  parameter int VAR_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [VAR_W-1:0]           cubeLastVar,
  input  logic [NUM_REQ-1:0]         reqValid,
  output logic [NUM_REQ-1:0]         reqReady,
  input  logic [NUM_REQ*TYPE_W-1:0]  reqType,
  input  logic [NUM_REQ*INDEX_W-1:0] reqF,
  input  logic [NUM_REQ*INDEX_W-1:0] reqG,
  input  logic [NUM_REQ*VAR_W-1:0]   reqTop,
  output logic [TYPE_W-1:0]          chkType,
  output logic [INDEX_W-1:0]         chkF,
  output logic [INDEX_W-1:0]         chkG,
  output logic [VAR_W-1:0]           chkTop,
  output logic [VAR_W-1:0]           chkCubeLastVar,
  input  logic                       chkHit,
  input  logic [INDEX_W-1:0]         chkResult,
  input  logic [TYPE_W-1:0]          chkOutType,
  input  logic [INDEX_W-1:0]         chkOutF,
  input  logic [INDEX_W-1:0]         chkOutG,
  output logic                       respValid,
  input  logic                       respReady,
  output logic [ID_W-1:0]            respId,
  output logic                       respHit,
  output logic [INDEX_W-1:0]         respResult,
  output logic [TYPE_W-1:0]          respType,
  output logic [INDEX_W-1:0]         respF,
  output logic [INDEX_W-1:0]         respG,
  output logic [CNT_W-1:0]           hitCount
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     grant_hi;
  logic [ID_W-1:0]     grant_lo;
  logic                found_hi;
  logic                found_lo;
  logic                accept;
  logic [TYPE_W-1:0]   sel_type;
  logic [INDEX_W-1:0]  sel_f;
  logic [INDEX_W-1:0]  sel_g;
  logic [VAR_W-1:0]    sel_top;

  assign chkCubeLastVar = cubeLastVar;
  assign respValid      = (state == RESP);

  // First valid above last_grant wins; otherwise wrap to the lowest valid.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqValid[i]) begin
        if (!found_hi && (ID_W'(i) > last_grant)) begin
          found_hi = 1'b1;
          grant_hi = ID_W'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          grant_lo = ID_W'(i);
        end
      end
    end
  end

  assign grant = found_hi ? grant_hi : grant_lo;

  always_comb begin
    sel_type = '0;
    sel_f    = '0;
    sel_g    = '0;
    sel_top  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_type = reqType[i*TYPE_W +: TYPE_W];
        sel_f    = reqF[i*INDEX_W +: INDEX_W];
        sel_g    = reqG[i*INDEX_W +: INDEX_W];
        sel_top  = reqTop[i*VAR_W +: VAR_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found_lo) begin
          accept    = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: state_nxt = RESP;
      RESP: begin
        if (respReady) begin
`ifdef APPLY_SCHED_BACK_TO_BACK_EN
          if (found_lo) begin
            accept    = 1'b1;
            state_nxt = EVAL;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    // No grant may leak out while reset is held.
    accept = accept & reset;
  end

  always_comb begin
    reqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqReady[i] = accept && (grant == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      chkType    <= '0;
      chkF       <= '0;
      chkG       <= '0;
      chkTop     <= '0;
      respId     <= '0;
      respHit    <= 1'b0;
      respResult <= '0;
      respType   <= '0;
      respF      <= '0;
      respG      <= '0;
      hitCount   <= '0;
    end else begin
      if (accept) begin
        chkType    <= sel_type;
        chkF       <= sel_f;
        chkG       <= sel_g;
        chkTop     <= sel_top;
        respId     <= grant;
        last_grant <= grant;
      end
      if (state == EVAL) begin
        respHit    <= chkHit;
        respResult <= chkResult;
        respType   <= chkOutType;
        respF      <= chkOutF;
        respG      <= chkOutG;
        if (chkHit && (hitCount != '1)) begin
          hitCount <= hitCount + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apply_case_scheduler.sv
// tb_apply_case_scheduler: table vectors, directed corners and random traffic
// checked against a transaction-level model of the scheduler.
`timescale 1ns/1ps
module tb_apply_case_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TYPE_W  = 3;
  localparam int INDEX_W = 30;
  localparam int VAR_W   = 16;
  localparam int CNT_W   = 4;
  localparam int HMAX    = (1 << CNT_W) - 1;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [VAR_W-1:0]           cubeLastVar;
  logic [NUM_REQ-1:0]         reqValid;
  logic [NUM_REQ-1:0]         reqReady;
  logic [NUM_REQ*TYPE_W-1:0]  reqType;
  logic [NUM_REQ*INDEX_W-1:0] reqF;
  logic [NUM_REQ*INDEX_W-1:0] reqG;
  logic [NUM_REQ*VAR_W-1:0]   reqTop;
  logic [TYPE_W-1:0]          chkType;
  logic [INDEX_W-1:0]         chkF;
  logic [INDEX_W-1:0]         chkG;
  logic [VAR_W-1:0]           chkTop;
  logic [VAR_W-1:0]           chkCubeLastVar;
  logic                       chkHit;
  logic [INDEX_W-1:0]         chkResult;
  logic [TYPE_W-1:0]          chkOutType;
  logic [INDEX_W-1:0]         chkOutF;
  logic [INDEX_W-1:0]         chkOutG;
  logic                       respValid;
  logic                       respReady;
  logic [ID_W-1:0]            respId;
  logic                       respHit;
  logic [INDEX_W-1:0]         respResult;
  logic [TYPE_W-1:0]          respType;
  logic [INDEX_W-1:0]         respF;
  logic [INDEX_W-1:0]         respG;
  logic [CNT_W-1:0]           hitCount;

  always #5 clk = ~clk;

  apply_case_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TYPE_W(TYPE_W),
    .INDEX_W(INDEX_W), .VAR_W(VAR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cubeLastVar(cubeLastVar),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqType(reqType), .reqF(reqF), .reqG(reqG), .reqTop(reqTop),
    .chkType(chkType), .chkF(chkF), .chkG(chkG), .chkTop(chkTop),
    .chkCubeLastVar(chkCubeLastVar),
    .chkHit(chkHit), .chkResult(chkResult), .chkOutType(chkOutType),
    .chkOutF(chkOutF), .chkOutG(chkOutG),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respHit(respHit), .respResult(respResult), .respType(respType),
    .respF(respF), .respG(respG), .hitCount(hitCount)
  );

  typedef struct {
    logic               hit;
    logic [INDEX_W-1:0] result;
    logic [TYPE_W-1:0]  typ;
    logic [INDEX_W-1:0] f;
    logic [INDEX_W-1:0] g;
  } cres_t;

  typedef struct {
    int                 id;
    logic [TYPE_W-1:0]  typ;
    logic [INDEX_W-1:0] f;
    logic [INDEX_W-1:0] g;
    logic [VAR_W-1:0]   top;
    logic               hit;
    logic [INDEX_W-1:0] result;
    int                 hits;
  } vec_t;

  // Stand-in for the shared checker.
  function automatic cres_t chk_fn(input logic [TYPE_W-1:0] t,
                                   input logic [INDEX_W-1:0] f,
                                   input logic [INDEX_W-1:0] g,
                                   input logic [VAR_W-1:0] top);
    cres_t r;
    r.hit    = (f[1:0] == g[1:0]);
    r.result = f & g;
    r.typ    = t ^ 3'b001;
    r.f      = f + INDEX_W'(top);
    r.g      = g - INDEX_W'(top);
    return r;
  endfunction

  cres_t cr;
  always_comb cr = chk_fn(chkType, chkF, chkG, chkTop);
  assign chkHit     = cr.hit;
  assign chkResult  = cr.result;
  assign chkOutType = cr.typ;
  assign chkOutF    = cr.f;
  assign chkOutG    = cr.g;

  int    errors = 0;
  int    checks = 0;
  int    m_last;
  bit    m_out;
  int    m_resp_at;
  int    m_id;
  int    m_hits;
  int    smp;
  cres_t m_exp;
  logic  last_rv;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [TYPE_W-1:0] t,
                         input logic [INDEX_W-1:0] f,
                         input logic [INDEX_W-1:0] g,
                         input logic [VAR_W-1:0] top);
    reqValid[i]                  = v;
    reqType[i*TYPE_W +: TYPE_W]  = t;
    reqF[i*INDEX_W +: INDEX_W]   = f;
    reqG[i*INDEX_W +: INDEX_W]   = g;
    reqTop[i*VAR_W +: VAR_W]     = top;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'b1, TYPE_W'($urandom), INDEX_W'($urandom),
            INDEX_W'($urandom), VAR_W'($urandom));
  endtask

  // One clock: check outputs at the falling edge against the model,
  // then return just after the next rising edge.
  task automatic cycle(output int gnt);
    logic ev;
    logic fr;
    logic hs;
    int   idx;
    logic [NUM_REQ-1:0] er;
    @(negedge clk);
    ev = m_out && (smp >= m_resp_at);
    if (m_out && smp == m_resp_at && m_exp.hit && m_hits < HMAX)
      m_hits++;
    last_rv = respValid;
    chk("respValid", respValid, ev);
    if (ev) begin
      chk("respId", respId, m_id);
      chk("respHit", respHit, m_exp.hit);
      chk("respResult", respResult, m_exp.result);
      chk("respType", respType, m_exp.typ);
      chk("respF", respF, m_exp.f);
      chk("respG", respG, m_exp.g);
    end
    chk("hitCount", hitCount, m_hits);
    chk("cubePass", chkCubeLastVar, cubeLastVar);
    fr = !m_out;
    hs = ev && respReady;
    if (hs) m_out = 0;
`ifdef APPLY_SCHED_BACK_TO_BACK_EN
    if (hs) fr = 1'b1;
`endif
    gnt = -1;
    if (fr) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_last + k) % NUM_REQ;
        if (gnt < 0 && reqValid[idx]) gnt = idx;
      end
    end
    er = '0;
    if (gnt >= 0) er[gnt] = 1'b1;
    chk("reqReady", reqReady, er);
    if (gnt >= 0) begin
      m_out     = 1'b1;
      m_resp_at = smp + 2;
      m_id      = gnt;
      m_last    = gnt;
      m_exp = chk_fn(reqType[gnt*TYPE_W +: TYPE_W],
                     reqF[gnt*INDEX_W +: INDEX_W],
                     reqG[gnt*INDEX_W +: INDEX_W],
                     reqTop[gnt*VAR_W +: VAR_W]);
    end
    smp++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    reqValid  = '1;
    respReady = 1'b0;
    #2;
    chk("rst_reqReady", reqReady, 0);
    chk("rst_respValid", respValid, 0);
    chk("rst_chk", {chkType, chkF, chkG, chkTop}, 0);
    chk("rst_resp", {respId, respHit, respResult, respType}, 0);
    chk("rst_respFG", {respF, respG}, 0);
    chk("rst_hitCount", hitCount, 0);
    reqValid = '0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    m_last = NUM_REQ - 1;
    m_out  = 1'b0;
    m_hits = 0;
    smp    = 0;
  endtask

  // Raise a request, wait for its grant, drop it, step through EVAL.
  task automatic issue(input int id, input logic [TYPE_W-1:0] t,
                       input logic [INDEX_W-1:0] f,
                       input logic [INDEX_W-1:0] g,
                       input logic [VAR_W-1:0] top);
    int gg;
    set_req(id, 1'b1, t, f, g, top);
    gg = -1;
    for (int k = 0; k < 8 && gg < 0; k++) cycle(gg);
    chk("issue_grant", gg, id);
    reqValid[id] = 1'b0;
    cycle(gg);
  endtask

  vec_t vecs[4];
  int   order[$];
  int   exp_order[5];
  int   g_t[$];
  int   rv_t[$];

  initial begin
    int g;
    int ngr;
    bit seen;
    cubeLastVar = 16'h00A5;
    reqType = '0; reqF = '0; reqG = '0; reqTop = '0;
    reqValid = '0; respReady = 1'b0;

    vecs[0] = '{1, 3'd2, 30'h5, 30'h9, 16'd3, 1'b1, 30'h1, 1};
    vecs[1] = '{0, 3'd1, 30'hC, 30'h3, 16'd1, 1'b0, 30'h0, 1};
    vecs[2] = '{3, 3'd7, 30'h3FFFFFFF, 30'h3FFFFFFF, 16'hFFFF,
                1'b1, 30'h3FFFFFFF, 2};
    vecs[3] = '{2, 3'd0, 30'h6, 30'hE, 16'd0, 1'b1, 30'h6, 3};
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();
    respReady = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].typ, vecs[i].f, vecs[i].g, vecs[i].top);
      chk("vec_valid", respValid, 1);
      chk("vec_id", respId, vecs[i].id);
      chk("vec_hit", respHit, vecs[i].hit);
      chk("vec_result", respResult, vecs[i].result);
      chk("vec_hits", hitCount, vecs[i].hits);
      cycle(g);
    end

    // All requesters busy: strict rotation.
    do_reset();
    respReady = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    order.delete();
    for (int k = 0; k < 40 && order.size() < 5; k++) begin
      cycle(g);
      if (g >= 0) begin
        order.push_back(g);
        rand_req(g);
      end
    end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("rr_order", order[i], exp_order[i]);
    reqValid = '0;
    for (int k = 0; k < 4; k++) cycle(g);

    // Consumer stalls: response must hold, no new grant.
    do_reset();
    issue(2, 3'd5, 30'h123, 30'h3A7, 16'h10);
    rand_req(0);
    ngr = 0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", respValid, 1);
      cycle(g);
      if (g >= 0) ngr++;
    end
    chk("hold_nogrant", ngr, 0);
    respReady = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      cycle(g);
      if (g == 0) seen = 1'b1;
    end
    chk("hold_release", seen, 1);
    reqValid = '0;
    for (int k = 0; k < 4; k++) cycle(g);

    // Reset lands during EVAL.
    do_reset();
    respReady = 1'b1;
    set_req(1, 1'b1, 3'd2, 30'h5, 30'h9, 16'd3);
    cycle(g);
    chk("mid_grant", g, 1);
    do_reset();
    respReady = 1'b1;
    for (int k = 0; k < 4; k++) cycle(g);
    chk("mid_hitCount", hitCount, 0);
    rand_req(1);
    rand_req(3);
    cycle(g);
    chk("mid_restart", g, 1);
    reqValid = '0;
    for (int k = 0; k < 4; k++) cycle(g);

    // Saturation of the hit counter.
    do_reset();
    respReady = 1'b1;
    for (int r = 0; r < HMAX - 1; r++) begin
      issue(0, 3'd1, 30'h4, 30'h8, 16'd1);
      cycle(g);
    end
    chk("sat_pre", hitCount, HMAX - 1);
    for (int r = 0; r < 2; r++) begin
      issue(0, 3'd1, 30'h4, 30'h8, 16'd1);
      cycle(g);
    end
    chk("sat_hold", hitCount, HMAX);

    // Spacing of grants and responses with two steady requesters.
    do_reset();
    respReady = 1'b1;
    rand_req(0);
    rand_req(2);
    g_t.delete();
    rv_t.delete();
    for (int k = 0; k < 14; k++) begin
      cycle(g);
      if (g >= 0) g_t.push_back(smp - 1);
      if (last_rv) rv_t.push_back(smp - 1);
    end
    reqValid = '0;
    if (g_t.size() >= 2 && rv_t.size() >= 2) begin
`ifdef APPLY_SCHED_BACK_TO_BACK_EN
      chk("b2b_grant", g_t[1], rv_t[0]);
      chk("b2b_space", rv_t[1] - rv_t[0], 2);
`else
      chk("seq_grant", g_t[1], rv_t[0] + 1);
      chk("seq_space", rv_t[1] - rv_t[0], 3);
`endif
    end else begin
      chk("spacing_events", 0, 1);
    end
    for (int k = 0; k < 4; k++) cycle(g);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      respReady = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) cubeLastVar = VAR_W'($urandom);
      cycle(g);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == g) begin
          if ($urandom_range(1) == 0) rand_req(i);
          else reqValid[i] = 1'b0;
        end else if (!reqValid[i]) begin
          if ($urandom_range(2) == 0) rand_req(i);
        end else if ($urandom_range(15) == 0) begin
          reqValid[i] = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apply_case_scheduler.md
Name: apply_case_scheduler

Overview:
- Shares one combinational simple-case/abstract-transform checker between NUM_REQ apply engines.
- Round-robin arbitrates incoming (type, f, g, top) requests and registers the winner's operands in front of the shared checker.
- Captures the checker's hit/result and transformed type/F/G, then returns them to the winner over a valid/ready response channel.
- Sits between the apply engines and the shared checker instance. Also keeps a saturating hit counter for profiling.

Parameters:
- NUM_REQ, 4, number of requesting apply engines (2..8).
- ID_W, 2, requester id width, >= clog2(NUM_REQ).
- TYPE_W, 3, operation type width.
- INDEX_W, 30, node index width.
- VAR_W, 16, variable index width.
- CNT_W, 16, hit counter width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cubeLastVar  input  VAR_W  shared cube last-variable configuration; stable while busy.
- reqValid  input  NUM_REQ  per-requester request valid.
- reqReady  output  NUM_REQ  one-hot grant/accept.
- reqType  input  NUM_REQ*TYPE_W  packed types; requester i occupies slice i.
- reqF  input  NUM_REQ*INDEX_W  packed f operands.
- reqG  input  NUM_REQ*INDEX_W  packed g operands.
- reqTop  input  NUM_REQ*VAR_W  packed top variables.
- chkType  output  TYPE_W  registered type driven to the checker.
- chkF  output  INDEX_W  registered f driven to the checker.
- chkG  output  INDEX_W  registered g driven to the checker.
- chkTop  output  VAR_W  registered top driven to the checker.
- chkCubeLastVar  output  VAR_W  cubeLastVar, passed straight through.
- chkHit  input  1  checker hit.
- chkResult  input  INDEX_W  checker result.
- chkOutType  input  TYPE_W  checker transformed type.
- chkOutF  input  INDEX_W  checker transformed F.
- chkOutG  input  INDEX_W  checker transformed G.
- respValid  output  1  response valid.
- respReady  input  1  response accepted by the consumer.
- respId  output  ID_W  index of the granted requester.
- respHit  output  1  captured hit.
- respResult  output  INDEX_W  captured result.
- respType  output  TYPE_W  captured transformed type.
- respF  output  INDEX_W  captured transformed F.
- respG  output  INDEX_W  captured transformed G.
- hitCount  output  CNT_W  saturating count of responses with hit=1.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and lastGrant = NUM_REQ-1.
  - All chk*, resp* and hitCount outputs clear to 0; reqReady = 0.
- States: IDLE, EVAL, RESP.
- IDLE:
  - Grant goes to the first i with reqValid[i]=1, searching lastGrant+1, lastGrant+2, ... modulo NUM_REQ.
  - reqReady[grant] = 1 combinationally in that same cycle. At most one reqReady bit is ever high, and only in IDLE.
  - On that edge: latch slice grant into chkType/chkF/chkG/chkTop, set respId = grant, lastGrant = grant, go to EVAL.
  - If no reqValid bit is set, stay in IDLE.
- EVAL (one cycle):
  - The checker settles on the registered operands.
  - On the edge: capture chkHit/chkResult/chkOutType/chkOutF/chkOutG into the resp* registers and go to RESP.
  - hitCount += chkHit, saturating at all-ones with no wrap.
- RESP:
  - respValid = 1. All resp* outputs are held stable until respReady = 1.
  - On respValid & respReady: go to IDLE; respValid drops the next cycle.
- Latency: request accepted at edge N, respValid high from cycle N+2. Minimum three cycles per request.
- Requester rules:
  - A requester holds reqValid and its operands stable until it sees reqReady.
  - Deasserting reqValid before the grant is allowed; that requester is simply skipped.
- Simultaneous requests: round-robin guarantees no requester waits longer than NUM_REQ-1 grants.
- Wrap-around: after lastGrant = NUM_REQ-1 the search restarts at 0.
- Reset mid-operation: the in-flight transaction is dropped silently with no response, and round-robin restarts from requester 0.
- cubeLastVar changing while in EVAL or RESP is a usage error. Its result is undefined but must not deadlock the FSM.

Optional Feature:
- Macro: APPLY_SCHED_BACK_TO_BACK_EN.
- When defined:
  - In RESP, if respReady = 1 and some reqValid is set, the next grant (computed from the updated lastGrant) is issued in the same cycle.
  - reqReady is high in that RESP cycle, operands are latched, and the FSM goes directly RESP->EVAL.
  - Sustained throughput becomes one request per 2 cycles.
- When undefined: RESP always returns to IDLE first, giving one request per 3 cycles.

Test Plan:
- Reset released; requester 1 only, type=2, f=0x5, g=0x9, top=3; model checker returns hit=1, result=0x1 -> reqReady=4'b0010 for one cycle; respValid two cycles later with respId=1, respHit=1, respResult=0x1; hitCount=1.
- All four reqValid high continuously, respReady always 1 -> grant order 0,1,2,3,0; each response's respId matches the grant.
- respReady held low 5 cycles in RESP -> resp* outputs unchanged, reqReady stays 0, no new grant until respReady rises.
- reset pulled low during EVAL, then released -> respValid never asserts for that transaction, hitCount=0, next grant goes to lowest valid index.
- Force hitCount to all-ones minus 1, issue two hit requests -> hitCount reads 0xFFFF and holds there.
- With APPLY_SCHED_BACK_TO_BACK_EN, requesters 0 and 2 valid, respReady=1 -> second reqReady coincides with first respValid cycle; 2-cycle spacing between respValid pulses.
